// File: rtl/gpo_access_arbiter_pkg.sv
// gpo_access_arbiter_pkg: shared widths, FSM state encoding and address decode helper
package gpo_access_arbiter_pkg;
    localparam int GPO_ADDR_W = 4;
    localparam int GPO_DATA_W = 8;
    localparam int GPO_SEL_W  = 16;

    typedef enum logic [1:0] {
        GPO_ARB_IDLE   = 2'd0,
        GPO_ARB_ACCESS = 2'd1,
        GPO_ARB_SETTLE = 2'd2,
        GPO_ARB_RESP   = 2'd3
    } gpo_arb_state_e;

    function automatic logic [GPO_SEL_W-1:0] gpo_onehot(input logic [GPO_ADDR_W-1:0] addr);
        return {{(GPO_SEL_W-1){1'b0}}, 1'b1} << addr;
    endfunction
endpackage

// File: rtl/gpo_access_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin arbiter
//  req_i[1:0] in  requests (bit 0 = A, bit 1 = B)
//  ptr_i      in  requester served last (0 = A, 1 = B)
//  gnt_o[1:0] out one-hot grant; on a tie the requester other than ptr_i wins
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);
    always_comb gnt_o = (&req_i) ? (ptr_i ? 2'b01 : 2'b10) : req_i;
endmodule

// File: rtl/gpo_access_arbiter.sv
// gpo_access_arbiter: shares the GPO bank access port between requesters A and B
//  SYSCLK/RESET                 clock, synchronous active-high reset
//  X_VALID/RD_WR/ADDR/WDATA     request from X (A or B), held until X_READY
//  X_READY                      combinational accept, only in IDLE
//  X_RSP_VALID/RDATA/ERR        registered one-cycle response
//  PORT_CS/OFFSET_SEL/RD_WR/DIN registered bank strobes, all 0 outside the access cycle
//  DOUT                         bank read data, registered by the bank
module gpo_access_arbiter
    import gpo_access_arbiter_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic                  SYSCLK,
    input  logic                  RESET,
    input  logic                  A_VALID,
    input  logic                  A_RD_WR,
    input  logic [GPO_ADDR_W-1:0] A_ADDR,
    input  logic [GPO_DATA_W-1:0] A_WDATA,
    output logic                  A_READY,
    output logic                  A_RSP_VALID,
    output logic [GPO_DATA_W-1:0] A_RSP_RDATA,
    output logic                  A_RSP_ERR,
    input  logic                  B_VALID,
    input  logic                  B_RD_WR,
    input  logic [GPO_ADDR_W-1:0] B_ADDR,
    input  logic [GPO_DATA_W-1:0] B_WDATA,
    output logic                  B_READY,
    output logic                  B_RSP_VALID,
    output logic [GPO_DATA_W-1:0] B_RSP_RDATA,
    output logic                  B_RSP_ERR,
    output logic                  PORT_CS,
    output logic [GPO_SEL_W-1:0]  OFFSET_SEL,
    output logic                  RD_WR,
    output logic [GPO_DATA_W-1:0] DIN,
    input  logic [GPO_DATA_W-1:0] DOUT
);
    gpo_arb_state_e        state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic                  id_q, id_d;
    logic                  rd_q, rd_d;
    logic                  err_q, err_d;
    logic [GPO_ADDR_W-1:0] addr_q, addr_d;
    logic [GPO_DATA_W-1:0] wdata_q, wdata_d;
    logic                  cs_q, cs_d;
    logic [GPO_SEL_W-1:0]  sel_q, sel_d;
    logic                  rdwr_q, rdwr_d;
    logic [GPO_DATA_W-1:0] din_q, din_d;
    logic                  a_rsp_q, a_rsp_d, b_rsp_q, b_rsp_d;
    logic [GPO_DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic                  a_err_q, a_err_d, b_err_q, b_err_d;

    logic [1:0]            gnt;
    logic                  accept;
    logic                  req_rd;
    logic                  req_err;
    logic [GPO_ADDR_W-1:0] req_addr;
    logic [GPO_DATA_W-1:0] req_wdata;
    logic [GPO_DATA_W-1:0] rsp_rdata;

    rr_arb2 u_arb (
        .req_i({B_VALID, A_VALID}),
        .ptr_i(ptr_q),
        .gnt_o(gnt)
    );

    assign A_READY   = (state_q == GPO_ARB_IDLE) & gnt[0];
    assign B_READY   = (state_q == GPO_ARB_IDLE) & gnt[1];
    assign accept    = A_READY | B_READY;
    assign req_rd    = gnt[1] ? B_RD_WR : A_RD_WR;
    assign req_addr  = gnt[1] ? B_ADDR  : A_ADDR;
    assign req_wdata = gnt[1] ? B_WDATA : A_WDATA;
    assign req_err   = int'(req_addr) >= NUM_REGS;
    // DOUT is valid during SETTLE and is captured straight into the response register
    assign rsp_rdata = (rd_q & ~err_q) ? DOUT : '0;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        rd_d      = rd_q;
        err_d     = err_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cs_d      = 1'b0;
        sel_d     = '0;
        rdwr_d    = 1'b0;
        din_d     = '0;
        a_rsp_d   = 1'b0;
        b_rsp_d   = 1'b0;
        a_rdata_d = '0;
        b_rdata_d = '0;
        a_err_d   = 1'b0;
        b_err_d   = 1'b0;
        case (state_q)
            GPO_ARB_IDLE: if (accept) begin
                state_d = GPO_ARB_ACCESS;
                id_d    = gnt[1];
                rd_d    = req_rd;
                err_d   = req_err;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                // bank strobes are registered, so they are loaded on the accept edge
                cs_d    = ~req_err;
                sel_d   = req_err ? '0 : gpo_onehot(req_addr);
                rdwr_d  = req_rd & ~req_err;
                din_d   = (req_rd | req_err) ? '0 : req_wdata;
            end
            GPO_ARB_ACCESS: state_d = GPO_ARB_SETTLE;
            GPO_ARB_SETTLE: begin
                state_d   = GPO_ARB_RESP;
                a_rsp_d   = ~id_q;
                b_rsp_d   = id_q;
                a_rdata_d = id_q ? '0 : rsp_rdata;
                b_rdata_d = id_q ? rsp_rdata : '0;
                a_err_d   = ~id_q & err_q;
                b_err_d   = id_q & err_q;
            end
            GPO_ARB_RESP: begin
                state_d = GPO_ARB_IDLE;
                ptr_d   = id_q;
            end
            default: state_d = GPO_ARB_IDLE;
        endcase
    end

    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            state_q   <= GPO_ARB_IDLE;
            ptr_q     <= 1'b1;
            id_q      <= 1'b0;
            rd_q      <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cs_q      <= 1'b0;
            sel_q     <= '0;
            rdwr_q    <= 1'b0;
            din_q     <= '0;
            a_rsp_q   <= 1'b0;
            b_rsp_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            a_err_q   <= 1'b0;
            b_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            rd_q      <= rd_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cs_q      <= cs_d;
            sel_q     <= sel_d;
            rdwr_q    <= rdwr_d;
            din_q     <= din_d;
            a_rsp_q   <= a_rsp_d;
            b_rsp_q   <= b_rsp_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
            a_err_q   <= a_err_d;
            b_err_q   <= b_err_d;
        end
    end

    assign PORT_CS     = cs_q;
    assign OFFSET_SEL  = sel_q;
    assign RD_WR       = rdwr_q;
    assign DIN         = din_q;
    assign A_RSP_VALID = a_rsp_q;
    assign A_RSP_RDATA = a_rdata_q;
    assign A_RSP_ERR   = a_err_q;
    assign B_RSP_VALID = b_rsp_q;
    assign B_RSP_RDATA = b_rdata_q;
    assign B_RSP_ERR   = b_err_q;
endmodule

// File: tb/tb_gpo_access_arbiter.sv
// tb_gpo_access_arbiter: directed and random checks of gpo_access_arbiter against a transaction-level model
module tb_gpo_access_arbiter;
    localparam int NR = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0, a_rd = 1'b0, b_valid = 1'b0, b_rd = 1'b0;
    logic [3:0]  a_addr = '0, b_addr = '0;
    logic [7:0]  a_wdata = '0, b_wdata = '0;
    logic        a_ready, a_rsp_valid, a_rsp_err, b_ready, b_rsp_valid, b_rsp_err;
    logic [7:0]  a_rsp_rdata, b_rsp_rdata;
    logic        port_cs, rd_wr;
    logic [15:0] offset_sel;
    logic [7:0]  din;
    logic [7:0]  dout = '0;
    logic [7:0]  bank [16] = '{default: 8'h00};
    int          checks = 0, errors = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gpo_access_arbiter #(.NUM_REGS(NR)) dut (
        .SYSCLK(clk), .RESET(rst),
        .A_VALID(a_valid), .A_RD_WR(a_rd), .A_ADDR(a_addr), .A_WDATA(a_wdata),
        .A_READY(a_ready), .A_RSP_VALID(a_rsp_valid), .A_RSP_RDATA(a_rsp_rdata), .A_RSP_ERR(a_rsp_err),
        .B_VALID(b_valid), .B_RD_WR(b_rd), .B_ADDR(b_addr), .B_WDATA(b_wdata),
        .B_READY(b_ready), .B_RSP_VALID(b_rsp_valid), .B_RSP_RDATA(b_rsp_rdata), .B_RSP_ERR(b_rsp_err),
        .PORT_CS(port_cs), .OFFSET_SEL(offset_sel), .RD_WR(rd_wr), .DIN(din), .DOUT(dout)
    );

    // register bank: registered DOUT on read, write on CS & ~RD_WR
    always @(posedge clk) if (port_cs)
        for (int i = 0; i < 16; i++) if (offset_sel[i]) begin
            if (rd_wr) dout <= bank[i];
            else bank[i] <= din;
        end

    // transaction-level model: one outstanding transaction, m_age = edges since accept
    bit         m_act = 1'b0, m_ptr = 1'b1, m_id = 1'b0, m_rd = 1'b0, m_err = 1'b0;
    int         m_age = 0;
    logic [3:0] m_addr = '0;
    logic [7:0] m_wd = '0, m_rdata = '0;
    logic [7:0] ref_mem [16] = '{default: 8'h00};

    function automatic bit wins_b(input bit va, input bit vb, input bit p);
        return vb && (!va || !p);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_act = 1'b0;
            m_ptr = 1'b1;
        end else if (m_act) begin
            m_age++;
            if (m_age == 3) begin
                m_act = 1'b0;
                m_ptr = m_id;
            end
        end else if (a_valid || b_valid) begin
            m_id    = wins_b(a_valid, b_valid, m_ptr);
            m_rd    = m_id ? b_rd : a_rd;
            m_addr  = m_id ? b_addr : a_addr;
            m_wd    = m_id ? b_wdata : a_wdata;
            m_err   = int'(m_addr) >= NR;
            m_rdata = (m_rd && !m_err) ? ref_mem[m_addr] : 8'h00;
            if (!m_rd && !m_err) ref_mem[m_addr] = m_wd;
            m_act   = 1'b1;
            m_age   = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    logic cs_e, rsp_a, rsp_b;
    assign cs_e  = m_act && m_age == 0 && !m_err;
    assign rsp_a = m_act && m_age == 2 && !m_id;
    assign rsp_b = m_act && m_age == 2 && m_id;

    always @(negedge clk) begin
        chk("A_READY", 32'(a_ready), 32'(!m_act && a_valid && !wins_b(a_valid, b_valid, m_ptr)));
        chk("B_READY", 32'(b_ready), 32'(!m_act && wins_b(a_valid, b_valid, m_ptr)));
        chk("PORT_CS", 32'(port_cs), 32'(cs_e));
        chk("OFFSET_SEL", 32'(offset_sel), cs_e ? (32'd1 << m_addr) : 32'd0);
        chk("RD_WR", 32'(rd_wr), 32'(cs_e && m_rd));
        chk("DIN", 32'(din), (cs_e && !m_rd) ? 32'(m_wd) : 32'd0);
        chk("A_RSP_VALID", 32'(a_rsp_valid), 32'(rsp_a));
        chk("A_RSP_RDATA", 32'(a_rsp_rdata), rsp_a ? 32'(m_rdata) : 32'd0);
        chk("A_RSP_ERR", 32'(a_rsp_err), 32'(rsp_a && m_err));
        chk("B_RSP_VALID", 32'(b_rsp_valid), 32'(rsp_b));
        chk("B_RSP_RDATA", 32'(b_rsp_rdata), rsp_b ? 32'(m_rdata) : 32'd0);
        chk("B_RSP_ERR", 32'(b_rsp_err), 32'(rsp_b && m_err));
    end

    // drive a request, wait (bounded) for READY, return 1ns after the accept edge
    task automatic send(input bit b, input bit rd, input logic [3:0] ad, input logic [7:0] wd);
        bit ok = 1'b0;
        if (b) begin b_valid = 1'b1; b_rd = rd; b_addr = ad; b_wdata = wd; end
        else begin a_valid = 1'b1; a_rd = rd; a_addr = ad; a_wdata = wd; end
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = b ? b_ready : a_ready;
        end
        chk("send_ready", 32'(ok), 32'd1);
        @(posedge clk); #1;
        if (b) b_valid = 1'b0; else a_valid = 1'b0;
    endtask

    initial begin
        bit acc_a, acc_b, who, seen;
        int last;
        repeat (2) @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_cs", 32'(port_cs), 32'd0);
        chk("rst_sel", 32'(offset_sel), 32'd0);
        chk("rst_rsp", 32'({a_rsp_valid, b_rsp_valid, a_rsp_err, b_rsp_err}), 32'd0);
        @(posedge clk); #1;
        // write A addr 3
        send(1'b0, 1'b0, 4'd3, 8'h5A);
        @(negedge clk);
        chk("t1_cs", 32'(port_cs), 32'd1);
        chk("t1_sel", 32'(offset_sel), 32'h0008);
        chk("t1_din", 32'(din), 32'h5A);
        repeat (2) @(negedge clk);
        chk("t1_rsp", 32'(a_rsp_valid), 32'd1);
        chk("t1_err", 32'(a_rsp_err), 32'd0);
        @(posedge clk); #1;
        // B reads it back
        send(1'b1, 1'b1, 4'd3, 8'h00);
        @(negedge clk);
        chk("t2_sel", 32'(offset_sel), 32'h0008);
        chk("t2_rdwr", 32'(rd_wr), 32'd1);
        repeat (2) @(negedge clk);
        chk("t2_rsp", 32'(b_rsp_valid), 32'd1);
        chk("t2_rdata", 32'(b_rsp_rdata), 32'h5A);
        chk("t2_a_quiet", 32'(a_rsp_valid), 32'd0);
        @(posedge clk); #1;
        // contention: A, B, A
        a_valid = 1'b1; a_rd = 1'b0; a_addr = 4'd1; a_wdata = 8'h11;
        b_valid = 1'b1; b_rd = 1'b0; b_addr = 4'd2; b_wdata = 8'h22;
        last = 0;
        for (int k = 0; k < 3; k++) begin
            seen = 1'b0;
            who = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (a_ready || b_ready) begin seen = 1'b1; who = b_ready; end
            end
            chk("t3_seen", 32'(seen), 32'd1);
            chk("t3_who", 32'(who), 32'(k == 1));
            if (k > 0) chk("t3_gap", 32'(cyc - last), 32'd4);
            last = cyc;
            @(posedge clk);
        end
        #1 a_valid = 1'b0; b_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
        // out-of-range read
        send(1'b0, 1'b1, 4'd9, 8'h00);
        @(negedge clk);
        chk("t4_cs", 32'(port_cs), 32'd0);
        repeat (2) @(negedge clk);
        chk("t4_rsp", 32'(a_rsp_valid), 32'd1);
        chk("t4_err", 32'(a_rsp_err), 32'd1);
        chk("t4_rdata", 32'(a_rsp_rdata), 32'd0);
        @(posedge clk); #1;
        // reset in the ACCESS cycle of a write
        send(1'b0, 1'b0, 4'd4, 8'h77);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_cs", 32'(port_cs), 32'd0);
        chk("t5_sel", 32'(offset_sel), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("t5_norsp", 32'(a_rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        a_valid = 1'b1; a_rd = 1'b1; a_addr = 4'd4;
        b_valid = 1'b1; b_rd = 1'b1; b_addr = 4'd5;
        @(negedge clk);
        chk("t5_a_first", 32'({a_ready, b_ready}), 32'b10);
        @(posedge clk); #1 a_valid = 1'b0; b_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
        // B raised during A's SETTLE
        send(1'b0, 1'b1, 4'd2, 8'h00);
        @(posedge clk); #1;
        b_valid = 1'b1; b_rd = 1'b1; b_addr = 4'd1;
        @(negedge clk);
        chk("t6_settle", 32'(b_ready), 32'd0);
        @(negedge clk);
        chk("t6_resp", 32'(b_ready), 32'd0);
        @(negedge clk);
        chk("t6_idle", 32'(b_ready), 32'd1);
        @(posedge clk); #1 b_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
        // random traffic with occasional resets and withdrawals
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            acc_a = a_valid && a_ready;
            acc_b = b_valid && b_ready;
            @(posedge clk); #1;
            rst = ($urandom_range(0, 79) == 0);
            if (acc_a || !a_valid) begin
                a_valid = ($urandom_range(0, 2) == 0);
                a_rd = 1'($urandom); a_addr = 4'($urandom); a_wdata = 8'($urandom);
            end else if ($urandom_range(0, 19) == 0) a_valid = 1'b0;
            if (acc_b || !b_valid) begin
                b_valid = ($urandom_range(0, 2) == 0);
                b_rd = 1'($urandom); b_addr = 4'($urandom); b_wdata = 8'($urandom);
            end else if ($urandom_range(0, 19) == 0) b_valid = 1'b0;
        end
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
